reset_req_gen: RTL and testbench

Generates the raw active-low system reset that feeds the design's reset synchronizer. Merges three reset sources (debounced pushbutton, software request, optional watchdog expiry) and a power-on reset into one glitch-free, stretched `RST_n` pulse with a hold-off window. Records which source caused the last reset. Sits at the top level, between the board pins and the reset synchronizer.

---
 rtl/reset_req_pkg.sv | 22 ++
 rtl/btn_debounce.sv | 45 ++++
 rtl/reset_req_gen.sv | 139 +++++++++++++
 tb/tb_reset_req_gen.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/reset_req_pkg.sv
// Shared types and helpers for the reset request generator.
package reset_req_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } rr_state_t;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'b00,
    CAUSE_BTN  = 2'b01,
    CAUSE_WDOG = 2'b10,
    CAUSE_SW   = 2'b11
  } rr_cause_t;

  // Counter width for a terminal count of n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton front end: two-flop synchronizer plus low-level debounce counter.
// Emits a single-cycle press once per qualified low period; re-armed on release.
module btn_debounce
  import reset_req_pkg::*;
#(
  parameter int DEB_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  localparam int              DW       = cnt_width(DEB_CYCLES);
  localparam logic [DW-1:0]   DEB_LAST = DW'(DEB_CYCLES - 1);

  logic [1:0]    sync_reg;
  logic [DW-1:0] cnt_reg;
  logic          armed_reg;
  logic          btn_low;

  assign btn_low = ~sync_reg[1];
  assign press   = armed_reg && btn_low && (cnt_reg == DEB_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg  <= 2'b11;
      cnt_reg   <= '0;
      armed_reg <= 1'b1;
    end else begin
      sync_reg <= {sync_reg[0], btn_n};
      if (!btn_low) begin
        cnt_reg   <= '0;
        armed_reg <= 1'b1;
      end else begin
        // Saturate so a long hold never wraps into a second press.
        if (cnt_reg != DEB_LAST)
          cnt_reg <= cnt_reg + 1'b1;
        if (press)
          armed_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/reset_req_gen.sv
// Merges POR, button, software and (with RSTGEN_WDOG_EN) watchdog requests into a
// stretched active-low RST_n pulse followed by a hold-off window; records the cause.
module reset_req_gen
  import reset_req_pkg::*;
#(
  parameter int PULSE_CYCLES   = 16,
  parameter int HOLDOFF_CYCLES = 8,
  parameter int DEB_CYCLES     = 1024,
  parameter int WDOG_CYCLES    = 2**20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_n,
  input  logic       sw_rst_req,
  input  logic       wdog_kick,
  output logic       RST_n,
  output logic [1:0] cause,
  output logic       busy
);

  localparam int            CNT_MAX    = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
  localparam int            CW         = cnt_width(CNT_MAX);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLDOFF_CYCLES - 1);

  rr_state_t     state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  rr_cause_t     cause_reg, cause_next;
  rr_cause_t     cause_out_reg;
  logic          rst_n_reg;
  logic          busy_reg;

  logic          btn_press;
  logic          wdog_fire;
  logic          req_any;
  rr_cause_t     req_cause;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn_debounce (
    .clk   (clk),
    .rst   (rst),
    .btn_n (btn_n),
    .press (btn_press)
  );

`ifdef RSTGEN_WDOG_EN
  localparam int            WW        = cnt_width(WDOG_CYCLES);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);

  logic [WW-1:0] wdog_cnt_reg;

  // A kick arriving in the expiry cycle suppresses the request.
  assign wdog_fire = (state_reg == IDLE) && (wdog_cnt_reg == WDOG_LAST) && !wdog_kick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wdog_cnt_reg <= '0;
    else if (wdog_kick || (state_reg != IDLE) || wdog_fire)
      wdog_cnt_reg <= '0;
    else if (wdog_cnt_reg != WDOG_LAST)
      wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
  end
`else
  logic unused_wdog;
  assign unused_wdog = wdog_kick | (WDOG_CYCLES == 0);
  assign wdog_fire   = 1'b0;
`endif

  always_comb begin
    req_cause = CAUSE_SW;
    if (btn_press)
      req_cause = CAUSE_BTN;
    else if (wdog_fire)
      req_cause = CAUSE_WDOG;
  end

  assign req_any = btn_press | wdog_fire | sw_rst_req;

  // Requests outside IDLE are simply not looked at, so they are dropped.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cause_next = cause_reg;
    unique case (state_reg)
      IDLE: begin
        if (req_any) begin
          state_next = ASSERT;
          cnt_next   = '0;
          cause_next = req_cause;
        end
      end
      ASSERT: begin
        if (cnt_reg == PULSE_LAST) begin
          state_next = HOLDOFF;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      HOLDOFF: begin
        if (cnt_reg == HOLD_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = ASSERT;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are registered from the current state, so they trail the FSM by one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ASSERT;
      cnt_reg       <= '0;
      cause_reg     <= CAUSE_POR;
      cause_out_reg <= CAUSE_POR;
      rst_n_reg     <= 1'b0;
      busy_reg      <= 1'b1;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      cause_reg     <= cause_next;
      cause_out_reg <= cause_reg;
      rst_n_reg     <= (state_reg != ASSERT);
      busy_reg      <= (state_reg != IDLE);
    end
  end

  assign RST_n = rst_n_reg;
  assign cause = cause_out_reg;
  assign busy  = busy_reg;

endmodule

// File: tb/tb_reset_req_gen.sv
// Bench for reset_req_gen: directed scenarios plus random traffic checked every cycle
// against a timestamp-based model of pulse/hold-off windows, debounce and watchdog rules.
module tb_reset_req_gen;

  localparam int P   = 4;
  localparam int H   = 3;
  localparam int DEB = 5;
  localparam int W   = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_n;
  logic       sw_rst_req;
  logic       wdog_kick;
  logic       RST_n;
  logic [1:0] cause;
  logic       busy;

  always #5 clk = ~clk;

  reset_req_gen #(
    .PULSE_CYCLES   (P),
    .HOLDOFF_CYCLES (H),
    .DEB_CYCLES     (DEB),
    .WDOG_CYCLES    (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_n      (btn_n),
    .sw_rst_req (sw_rst_req),
    .wdog_kick  (wdog_kick),
    .RST_n      (RST_n),
    .cause      (cause),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model state: edge index, edge of the last accepted reset, cause history.
  int n;
  int s_start;
  int last_kick;
  int btn_run;
  bit pipe_d1, pipe_d2;
  bit in_rst;
  int prev_cause, new_cause;
  int exp_falls, obs_falls;
  bit prev_rst_n;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", tag, n, obs, exp);
    end
  endtask

  task automatic step(input bit sw, input bit kick, input bit btn);
    bit idle, press_now, wd_now;
    int e_rst_n, e_busy, e_cause, c;
    sw_rst_req = sw;
    wdog_kick  = kick;
    btn_n      = btn;
    @(posedge clk);
    n++;
    if (!in_rst) begin
      // Requests are honoured once RST_n has been high for H edges.
      idle      = (n >= s_start + P + H + 1);
      press_now = pipe_d2;
      pipe_d2   = pipe_d1;
      btn_run   = btn ? 0 : btn_run + 1;
      pipe_d1   = (btn_run == DEB);
      wd_now    = 1'b0;
`ifdef RSTGEN_WDOG_EN
      begin : wd_model
        int ref_edge;
        ref_edge = (last_kick > s_start + P + H) ? last_kick : s_start + P + H;
        wd_now   = idle && !kick && (n - ref_edge >= W);
      end
`endif
      if (kick)
        last_kick = n;
      if (idle && (press_now || wd_now || sw)) begin
        c          = press_now ? 1 : (wd_now ? 2 : 3);
        s_start    = n;
        exp_falls++;
        prev_cause = new_cause;
        new_cause  = c;
        $display("edge %0d: reset request accepted, cause %0d", n, c);
      end
    end
    #1;
    if (in_rst) begin
      e_rst_n = 0;
      e_busy  = 1;
      e_cause = 0;
    end else begin
      e_rst_n = (n >= s_start + 1 && n <= s_start + P) ? 0 : 1;
      e_busy  = (n >= s_start + 1 && n <= s_start + P + H) ? 1 : 0;
      e_cause = (n >= s_start + 1) ? new_cause : prev_cause;
    end
    check("rst_n", RST_n, e_rst_n);
    check("busy", busy, e_busy);
    check("cause", cause, e_cause);
    if (prev_rst_n && !RST_n)
      obs_falls++;
    prev_rst_n = RST_n;
  endtask

  task automatic do_reset(input int cycles);
    rst    = 1'b1;
    in_rst = 1'b1;
    #1;
    check("rst_async_rst_n", RST_n, 0);
    check("rst_async_busy", busy, 1);
    check("rst_async_cause", cause, 0);
    repeat (cycles) step(1'b0, 1'b0, 1'b1);
    rst        = 1'b0;
    in_rst     = 1'b0;
    s_start    = n;
    prev_cause = 0;
    new_cause  = 0;
    btn_run    = 0;
    pipe_d1    = 1'b0;
    pipe_d2    = 1'b0;
    prev_rst_n = 1'b0;
  endtask

  task automatic seg_check(input string tag);
    $display("segment %s: %0d resets seen, %0d predicted", tag, obs_falls, exp_falls);
    check(tag, obs_falls, exp_falls);
    obs_falls = 0;
    exp_falls = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit rb;
    int left;
    n = 0; s_start = -100; last_kick = -1000; btn_run = 0;
    pipe_d1 = 0; pipe_d2 = 0; in_rst = 0; prev_cause = 0; new_cause = 0;
    exp_falls = 0; obs_falls = 0; prev_rst_n = 0;
    sw_rst_req = 1'b0; wdog_kick = 1'b0; btn_n = 1'b1;

    // Power-on reset
    do_reset(3);
    repeat (12) step(1'b0, 1'b1, 1'b1);
    seg_check("por");

    // Software request, then a second one dropped in hold-off
    step(1'b1, 1'b1, 1'b1);
    repeat (5) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    repeat (12) step(1'b0, 1'b1, 1'b1);
    seg_check("sw");

    // Bouncing button, long hold, release, short press
    repeat (2) begin
      repeat (3) step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1);
    end
    repeat (40) step(1'b0, 1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b1, 1'b1);
    repeat (6)  step(1'b0, 1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b1, 1'b1);
    seg_check("button");

    // Watchdog expiry, regular kicks, kick coincident with expiry
    repeat (25) step(1'b0, 1'b0, 1'b1);
    repeat (10) step(1'b0, 1'b1, 1'b1);
    seg_check("wdog_expire");
    for (int i = 0; i < 200; i++) step(1'b0, (i % 15) == 14, 1'b1);
    seg_check("wdog_kicked");
    step(1'b0, 1'b1, 1'b1);
    repeat (W - 1) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    repeat (5) step(1'b0, 1'b1, 1'b1);
    seg_check("wdog_kick_at_expiry");

    // Software request coincident with a qualified press
    repeat (DEB + 1) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    repeat (5)  step(1'b0, 1'b1, 1'b0);
    repeat (15) step(1'b0, 1'b1, 1'b1);
    seg_check("btn_vs_sw");

    // Power-on reset arriving mid-pulse
    step(1'b1, 1'b1, 1'b1);
    repeat (2) step(1'b0, 1'b1, 1'b1);
    do_reset(2);
    repeat (15) step(1'b0, 1'b1, 1'b1);
    seg_check("rst_mid_assert");

    // Long stretch without kicks
    repeat (100) step(1'b0, 1'b0, 1'b1);
    seg_check("no_kicks");

    // Random traffic
    rb = 1'b1;
    left = 10;
    for (int i = 0; i < 600; i++) begin
      if (left == 0) begin
        rb   = ~rb;
        left = rb ? int'($urandom_range(1, 8)) : int'($urandom_range(1, 10));
      end
      left--;
      step($urandom_range(0, 39) == 0, $urandom_range(0, 11) == 0, rb);
    end
    seg_check("random");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
